// File: rtl/bitonic_sorter_n_pkg.sv
// bitonic_sorter_n_pkg: shared pair type, compare-swap and bitonic stage indexing helpers
`ifndef INDEX_FLAT_SVH
`define INDEX_FLAT_SVH
`define INDEX_FLAT(i) ((i) * PAIR_W)
`endif

package bitonic_sorter_n_pkg;
    localparam int KEY_W = 16;

    // lo occupies the upper bits so the packed value orders by lo, then hi
    typedef struct packed {
        logic [KEY_W-1:0] lo;
        logic [KEY_W-1:0] hi;
    } tuple_pair_t;

    localparam int PAIR_W = $bits(tuple_pair_t);

    function automatic logic cmp_swp(tuple_pair_t a, tuple_pair_t b, logic desc);
        return desc ? ({a.lo, a.hi} < {b.lo, b.hi}) : ({a.lo, a.hi} > {b.lo, b.hi});
    endfunction

    function automatic int sort_lg(int n);
        return $clog2(n);
    endfunction

    function automatic int sort_stages(int n);
        return sort_lg(n) * (sort_lg(n) + 1) / 2;
    endfunction

    // Stage order is a prefix common to every N, so walking up to 64 is enough
    function automatic int stage_kj(int s, logic want_j);
        int c = 0;
        int r = 0;
        for (int k = 2; k <= 64; k *= 2)
            for (int j = k / 2; j >= 1; j /= 2) begin
                c++;
                if (c == s) r = want_j ? j : k;
            end
        return r;
    endfunction

    function automatic int stage_k(int s);
        return stage_kj(s, 1'b0);
    endfunction

    function automatic int stage_j(int s);
        return stage_kj(s, 1'b1);
    endfunction
endpackage

// File: rtl/sort_stage_n.sv
// sort_stage_n: one registered compare-exchange layer with its valid/desc flags
module sort_stage_n
    import bitonic_sorter_n_pkg::*;
#(
    parameter int N = 16,
    parameter int STAGE_IDX = 1,
    localparam int FLAT_W = N * PAIR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_desc,
    input  logic [FLAT_W-1:0] in_pairs,
    output logic              out_valid,
    output logic              out_desc,
    output logic [FLAT_W-1:0] out_pairs
);
    localparam int K = stage_k(STAGE_IDX);
    localparam int J = stage_j(STAGE_IDX);

    tuple_pair_t a [N];
    tuple_pair_t x [N];
    logic valid_q, valid_d, desc_q, desc_d;
    logic [FLAT_W-1:0] pairs_q, pairs_d;

    always_comb begin
        for (int i = 0; i < N; i++) a[i] = in_pairs[`INDEX_FLAT(i) +: PAIR_W];
        x = a;
        // Lower index of each pair does the exchange; block direction flips with bit K
        for (int i = 0; i < N; i++)
            if ((i & J) == 0 && cmp_swp(a[i], a[i ^ J], ((i & K) != 0) ^ in_desc)) begin
                x[i] = a[i ^ J];
                x[i ^ J] = a[i];
            end
        valid_d = en ? in_valid : valid_q;
        desc_d = en ? in_desc : desc_q;
        pairs_d = pairs_q;
        for (int i = 0; i < N; i++) if (en) pairs_d[`INDEX_FLAT(i) +: PAIR_W] = x[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            desc_q <= 1'b0;
            pairs_q <= '0;
        end else begin
            valid_q <= valid_d;
            desc_q <= desc_d;
            pairs_q <= pairs_d;
        end
    end

    assign out_valid = valid_q;
    assign out_desc = desc_q;
    assign out_pairs = pairs_q;
endmodule

// File: rtl/bitonic_sorter_n.sv
// bitonic_sorter_n: fully pipelined bitonic sorter of N (lo,hi) pairs with a global stall
module bitonic_sorter_n
    import bitonic_sorter_n_pkg::*;
#(
    parameter int N = 16,
    localparam int LG = $clog2(N),
    localparam int STAGES = LG * (LG + 1) / 2,
    localparam int FLAT_W = N * PAIR_W,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_desc,
    input  logic [FLAT_W-1:0] pairs_in_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_desc,
    output logic [FLAT_W-1:0] pairs_out_flat,
    output logic [OCC_W-1:0]  occupancy
);
    logic advance, hand;
    logic valid_c [STAGES+1];
    logic desc_c [STAGES+1];
    logic [FLAT_W-1:0] pairs_c [STAGES+1];
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    assign advance = out_ready | ~out_valid;
    assign in_ready = advance;
    assign valid_c[0] = in_valid & advance;
    assign desc_c[0] = in_desc;
    assign pairs_c[0] = pairs_in_flat;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        sort_stage_n #(.N(N), .STAGE_IDX(s + 1)) u_stage (
            .clock    (clock),
            .reset    (reset),
            .en       (advance),
            .in_valid (valid_c[s]),
            .in_desc  (desc_c[s]),
            .in_pairs (pairs_c[s]),
            .out_valid(valid_c[s+1]),
            .out_desc (desc_c[s+1]),
            .out_pairs(pairs_c[s+1])
        );
    end

    assign out_valid = valid_c[STAGES];
    assign out_desc = desc_c[STAGES];
    assign pairs_out_flat = pairs_c[STAGES];
    assign hand = out_valid & out_ready;

    always_comb begin
        occupancy_d = occupancy_q + OCC_W'(valid_c[0]) - OCC_W'(hand);
    end

    always_ff @(posedge clock) begin
        if (reset) occupancy_q <= '0;
        else occupancy_q <= occupancy_d;
    end

    assign occupancy = occupancy_q;
endmodule

// File: tb/tb_bitonic_sorter_n.sv
// tb_bitonic_sorter_n: directed checks of the N=8, N=16 and N=2 sorters
module tb_bitonic_sorter_n;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic iv8, ir8, id8, ov8, or8, od8;
    logic [255:0] pin8, pout8;
    logic [2:0] occ8;
    logic iv16, ir16, id16, ov16, or16, od16;
    logic [511:0] pin16, pout16;
    logic [3:0] occ16;
    logic iv2, ir2, id2, ov2, or2, od2;
    logic [63:0] pin2, pout2;
    logic [0:0] occ2;

    bitonic_sorter_n #(.N(8)) u8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_desc(id8),
        .pairs_in_flat(pin8), .out_valid(ov8), .out_ready(or8), .out_desc(od8),
        .pairs_out_flat(pout8), .occupancy(occ8));
    bitonic_sorter_n #(.N(16)) u16 (
        .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_desc(id16),
        .pairs_in_flat(pin16), .out_valid(ov16), .out_ready(or16), .out_desc(od16),
        .pairs_out_flat(pout16), .occupancy(occ16));
    bitonic_sorter_n #(.N(2)) u2 (
        .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_desc(id2),
        .pairs_in_flat(pin2), .out_valid(ov2), .out_ready(or2), .out_desc(od2),
        .pairs_out_flat(pout2), .occupancy(occ2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pr(input int lo, input int hi);
        return {lo[15:0], hi[15:0]};
    endfunction

    function automatic logic [511:0] rnd16();
        logic [511:0] v;
        for (int i = 0; i < 16; i++)
            v[i*32 +: 32] = {16'($urandom_range(0, 15)), 16'($urandom_range(0, 3))};
        return v;
    endfunction

    function automatic logic [511:0] ref_sort(input logic [511:0] v, input logic desc);
        logic [31:0] e [16];
        logic [31:0] t;
        logic [511:0] r;
        for (int i = 0; i < 16; i++) e[i] = v[i*32 +: 32];
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15 - i; j++)
                if (desc ? e[j] < e[j+1] : e[j] > e[j+1]) begin
                    t = e[j];
                    e[j] = e[j+1];
                    e[j+1] = t;
                end
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = e[i];
        return r;
    endfunction

    int s1_lo [8] = '{7, 3, 5, 1, 8, 2, 6, 4};
    int s2_lo [8] = '{4, 4, 4, 4, 1, 1, 1, 1};
    int s2_elo [8] = '{4, 4, 4, 4, 1, 1, 1, 1};
    int s2_ehi [8] = '{3, 2, 1, 0, 7, 6, 5, 4};

    initial begin
        logic [255:0] e8;
        logic [511:0] vecs [20];
        logic [511:0] q4 [$];
        logic [511:0] cur, snap;
        int lat, got, first, last, k, nacc;
        reset = 1'b1;
        {iv8, id8, iv16, id16, iv2, id2} = '0;
        {pin8, pin16, pin2} = '0;
        {or8, or16, or2} = 3'b111;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst out_valid8", ov8, 0);
        chk("rst occ8", occ8, 0);
        chk("rst pairs8", pout8, 0);
        chk("rst in_ready8", ir8, 1);

        // Scenario 1: N=8 ascending, latency 6
        for (int i = 0; i < 8; i++) pin8[i*32 +: 32] = pr(s1_lo[i], 0);
        id8 = 1'b0;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk("s1 occ after accept", occ8, 1);
        lat = 1;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        chk("s1 latency", lat, 6);
        for (int i = 0; i < 8; i++) e8[i*32 +: 32] = pr(i + 1, 0);
        chk("s1 data", pout8, e8);
        chk("s1 desc", od8, 0);
        chk("s1 occ at output", occ8, 1);
        tick();
        chk("s1 occ drained", occ8, 0);
        chk("s1 out_valid drained", ov8, 0);

        // Scenario 2: N=8 descending with tie groups
        for (int i = 0; i < 8; i++) pin8[i*32 +: 32] = pr(s2_lo[i], i);
        id8 = 1'b1;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        chk("s2 latency", lat, 6);
        for (int i = 0; i < 8; i++) e8[i*32 +: 32] = pr(s2_elo[i], s2_ehi[i]);
        chk("s2 data", pout8, e8);
        chk("s2 desc", od8, 1);
        tick();

        // Scenario 6: N=2 single stage
        pin2 = {pr(2, 5), pr(9, 0)};
        id2 = 1'b0;
        iv2 = 1'b1;
        chk("s6 in_ready", ir2, 1);
        tick();
        iv2 = 1'b0;
        chk("s6 out_valid latency 1", ov2, 1);
        chk("s6 data", pout2, {pr(9, 0), pr(2, 5)});
        chk("s6 occ", occ2, 1);
        tick();
        chk("s6 drained", ov2, 0);

        // Scenario 3: 20 back-to-back vectors alternating direction
        for (int i = 0; i < 20; i++) vecs[i] = rnd16();
        got = 0;
        first = 0;
        last = 0;
        for (int c = 0; c < 40; c++) begin
            iv16 = c < 20;
            if (c < 20) begin
                pin16 = vecs[c];
                id16 = c[0];
            end
            tick();
            if (ov16) begin
                if (got == 0) first = c;
                last = c;
                if (got < 20) begin
                    chk("s3 data", pout16, ref_sort(vecs[got], got[0]));
                    chk("s3 desc", od16, got[0]);
                end
                got++;
            end
        end
        chk("s3 count", got, 20);
        chk("s3 consecutive", last - first, 19);

        // Scenario 4: stall downstream while feeding
        or16 = 1'b0;
        nacc = 0;
        cur = rnd16();
        for (int c = 0; c < 12; c++) begin
            iv16 = 1'b1;
            pin16 = cur;
            id16 = nacc[0];
            if (ir16) begin
                q4.push_back(cur);
                nacc++;
                cur = rnd16();
            end
            tick();
        end
        chk("s4 accepted", nacc, 10);
        chk("s4 in_ready low", ir16, 0);
        chk("s4 occ saturated", occ16, 10);
        chk("s4 out_valid", ov16, 1);
        snap = pout16;
        tick();
        chk("s4 hold data", pout16, snap);
        chk("s4 hold desc", od16, 0);
        chk("s4 hold occ", occ16, 10);
        or16 = 1'b1;
        iv16 = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            if (ov16) begin
                if (k < 10) begin
                    chk("s4 drain data", pout16, ref_sort(q4[k], k[0]));
                    chk("s4 drain desc", od16, k[0]);
                end
                k++;
            end
            tick();
        end
        chk("s4 drain count", k, 10);
        chk("s4 occ empty", occ16, 0);

        // Scenario 5: reset with 4 vectors in flight
        for (int c = 0; c < 4; c++) begin
            iv16 = 1'b1;
            pin16 = rnd16();
            id16 = 1'b0;
            tick();
        end
        iv16 = 1'b0;
        chk("s5 occ before reset", occ16, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5 out_valid after reset", ov16, 0);
        chk("s5 occ after reset", occ16, 0);
        chk("s5 pairs after reset", pout16, 0);
        chk("s5 in_ready after reset", ir16, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("s5 no stale output", ov16, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bitonic_sorter_n.md
BITONIC_SORTER_N -- requirements
Module: bitonic_sorter_n

Interface
REQ-001 SHALL have parameter N, default 16, number of tuple pairs per vector; power of two, 2..64.
REQ-002 SHALL have derived constant LG = log2(N) and STAGES = LG*(LG+1)/2, the number of compare-exchange stages.
REQ-003 SHALL have derived constant FLAT_W = N*PAIR_W.
REQ-004 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input vector is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the vector this cycle.
REQ-008 SHALL have port in_desc, input, 1 bit: 0 = ascending sort, 1 = descending sort, sampled per vector.
REQ-009 SHALL have port pairs_in_flat, input, FLAT_W bits: element i at bits [i*PAIR_W +: PAIR_W].
REQ-010 SHALL have port out_valid, output, 1 bit: a sorted vector is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-012 SHALL have port out_desc, output, 1 bit: the in_desc value that travelled with the vector.
REQ-013 SHALL have port pairs_out_flat, output, FLAT_W bits: the sorted vector, same packing as the input.
REQ-014 SHALL have port occupancy, output, clog2(STAGES+1) bits: count of valid vectors held in the pipeline.

Function
REQ-015 SHALL implement a bitonic sorting network of STAGES registered stages, one compare-exchange layer per stage.
REQ-016 SHALL order pairs by the lo field, with ties broken by the hi field; fully equal pairs keep arbitrary relative order.
REQ-017 SHALL carry a valid bit and the desc bit in every stage, so vectors of mixed direction may be in flight together.
REQ-018 SHALL use a global advance signal: advance = out_ready OR NOT out_valid; when advance=0 every stage register holds.
REQ-019 SHALL drive in_ready = advance, combinationally, with no combinational path from in_valid to in_ready.
REQ-020 SHALL capture a vector into stage 1 only on in_valid AND in_ready; otherwise stage 1 loads a bubble (valid=0) when advancing.
REQ-021 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when out_ready is held at 1.
REQ-022 SHALL sustain a throughput of one vector per cycle; bubbles are not collapsed.
REQ-023 SHALL hold out_valid, pairs_out_flat and out_desc stable while out_valid=1 AND out_ready=0.
REQ-024 SHALL update occupancy each cycle: +1 on acceptance, -1 on output handshake, unchanged when both or neither occur.
REQ-025 SHALL keep occupancy at most STAGES at all times.
REQ-026 SHALL pass pairs through each stage unchanged except where that stage's compare-exchange swaps them.
REQ-027 SHALL leave the data values of invalid stages unspecified; only valid-qualified data is checked.
REQ-028 SHALL treat N=2 as a single-stage network with latency 1.

Reset
REQ-029 SHALL, while reset=1, clear every stage valid bit, out_valid, out_desc, occupancy and pairs_out_flat to 0 on the next clock edge.
REQ-030 SHALL drop all vectors in flight when reset is asserted mid-operation, with no partial output afterwards.
REQ-031 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL take tuple_pair_t, PAIR_W, the cmp_swp(a, b, desc) function and the index_flat macro from the shared aoc5 header/package.
REQ-033 SHALL place the derived stage constants and the compare-index helper functions in that shared package.
REQ-034 SHALL instantiate, STAGES times through a generate loop, a sub-module sort_stage_n (parameters N, STAGE_IDX) containing one compare-exchange layer plus its valid/desc registers and enable input.

Verification
REQ-035 Scenario 1: N=8, asc, lo values {7,3,5,1,8,2,6,4} -> output lo {1..8} after exactly 6 cycles, occupancy 1 then 0.
REQ-036 Scenario 2: N=8, desc, ties lo={4,4,4,4,1,1,1,1} with hi={0..7} -> output lo {4,4,4,4,1,1,1,1} with hi descending within each tie group.
REQ-037 Scenario 3: N=16, 20 back-to-back random vectors alternating asc/desc, out_ready=1 -> 20 outputs on consecutive cycles, each matching the model with the correct out_desc.
REQ-038 Scenario 4: out_ready=0 for 12 cycles while feeding in_valid=1 -> in_ready falls, occupancy saturates at STAGES, output stable; after release all vectors emerge in order with no loss or duplication.
REQ-039 Scenario 5: reset asserted for 1 cycle with occupancy 4 -> out_valid=0 and occupancy=0 next cycle; no stale vector emerges in the following 10 cycles.
REQ-040 Scenario 6: N=2 {(9,0),(2,5)}, asc -> {(2,5),(9,0)} with latency 1.
